// File: rtl/scanner_link_pkg.sv
// Constants shared by both ends of the scanner serial link.
// The scanner-side transmitter reuses the code values and frame size defined here.
package scanner_link_pkg;

  localparam int DATA_BITS_DEF = 1024;
  localparam int CODE_BITS_DEF = 8;
  localparam int TIMEOUT_DEF   = 4096;

  localparam logic [7:0] CODE_50   = 8'd1;
  localparam logic [7:0] CODE_80   = 8'd2;
  localparam logic [7:0] CODE_90   = 8'd3;
  localparam logic [7:0] CODE_100  = 8'd4;
  localparam logic [7:0] CODE_DATA = 8'd7;

  typedef enum logic [1:0] {
    RX_CODE = 2'd0,
    RX_DATA = 2'd1,
    DRAIN   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/link_deserializer.sv
// Bit-level side of the scanner link: shift register, bit counter, byte strobe
// and the backpressure that keeps a stalled byte from being overwritten.
import scanner_link_pkg::*;

module link_deserializer #(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CODE_BITS = CODE_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clear,
  input  logic       drop,
  input  logic       data_mode,
  input  logic       transfer_clock,
  input  logic       transfer_data,
  input  logic       out_ready,
  output logic       transfer_ready,
  output logic       accept,
  output logic       code_done,
  output logic       frame_last,
  output logic       bits_pending,
  output logic [7:0] code,
  output logic [7:0] out_byte,
  output logic       out_valid
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CODE_END  = CNT_W'(CODE_BITS);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(DATA_BITS);

  logic [7:0]       shreg;
  logic [7:0]       shreg_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             byte_done;

  // Ready is also held low while the link is disabled, so nothing is taken then.
  assign transfer_ready = en && !(out_valid && !out_ready);
  assign accept         = transfer_ready && transfer_clock;
  assign shreg_nxt      = {shreg[6:0], transfer_data};
  assign cnt_nxt        = bit_cnt + CNT_W'(1);
  assign code_done      = accept && !data_mode && (cnt_nxt == CODE_END);
  assign frame_last     = accept && data_mode && (cnt_nxt == FRAME_END);
  assign byte_done      = accept && data_mode && (cnt_nxt[2:0] == 3'd0);
  assign bits_pending   = (bit_cnt != '0);
  assign code           = shreg_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= shreg_nxt;
      bit_cnt <= (code_done || frame_last) ? '0 : cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_byte  <= '0;
      out_valid <= 1'b0;
    end else if (drop) begin
      out_valid <= 1'b0;
    end else if (byte_done) begin
      out_byte  <= shreg_nxt;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/scanner_link_receiver.sv
// Gondola-side scanner link receiver: code/frame FSM, permit and flush handshakes
// toward the scanner, and the inactivity timeout.
import scanner_link_pkg::*;

module scanner_link_receiver #(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CODE_BITS = CODE_BITS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       transfer_data,
  input  logic       transfer_clock,
  output logic       transfer_ready,
  output logic       active,
  output logic       transfer_permit,
  output logic       flush,
  input  logic       link_enable,
  input  logic       host_request,
  input  logic       host_flush,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] fill_code,
  output logic       status_pulse,
  output logic       frame_done,
  output logic       error,
  output logic [1:0] state
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  rx_state_t        state_q, state_d;
  logic             permit_armed, armed_d;
  logic             flush_sent, flush_sent_d;
  logic [2:0]       fill_d;
  logic             status_d, error_d, flush_d, frame_done_d;
  logic [TMO_W-1:0] tmo_cnt;
  logic             des_en, accept, code_done, frame_last, bits_pending;
  logic             tmo_run, timeout_hit;
  logic [7:0]       code;

  assign des_en = active && (state_q != DRAIN);

  link_deserializer #(
    .DATA_BITS (DATA_BITS),
    .CODE_BITS (CODE_BITS)
  ) u_des (
    .clk            (clk),
    .rst            (rst),
    .en             (des_en),
    .clear          (!active || timeout_hit),
    .drop           (timeout_hit),
    .data_mode      (state_q == RX_DATA),
    .transfer_clock (transfer_clock),
    .transfer_data  (transfer_data),
    .out_ready      (out_ready),
    .transfer_ready (transfer_ready),
    .accept         (accept),
    .code_done      (code_done),
    .frame_last     (frame_last),
    .bits_pending   (bits_pending),
    .code           (code),
    .out_byte       (out_byte),
    .out_valid      (out_valid)
  );

  // A stalled consumer does not count as scanner silence.
  assign tmo_run     = bits_pending || (state_q == RX_DATA && transfer_ready);
  assign timeout_hit = tmo_run && !accept && (tmo_cnt == TMO_LAST);

  assign transfer_permit = permit_armed && (fill_code >= 3'(CODE_80)) && (state_q == RX_CODE);
  assign state           = state_q;

  always_ff @(posedge clk) begin
    if (rst || !active || accept || !tmo_run || timeout_hit) tmo_cnt <= '0;
    else                                                     tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_code;
    armed_d      = permit_armed || host_request;
    flush_sent_d = flush_sent;
    status_d     = 1'b0;
    error_d      = timeout_hit;
    flush_d      = 1'b0;
    frame_done_d = 1'b0;

    if (state_q == RX_CODE && host_flush && !host_request && fill_code == 3'(CODE_100) &&
        !permit_armed && !flush_sent) begin
      flush_d      = 1'b1;
      flush_sent_d = 1'b1;
    end

    case (state_q)
      RX_CODE: begin
        if (code_done) begin
          case (code)
            CODE_50, CODE_80, CODE_90, CODE_100: begin
              fill_d       = code[2:0];
              status_d     = 1'b1;
              flush_sent_d = 1'b0;
            end
            CODE_DATA: begin
              state_d = RX_DATA;
              armed_d = 1'b0;
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      RX_DATA: begin
        if (timeout_hit)     state_d = RX_CODE;
        else if (frame_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          state_d      = RX_CODE;
          frame_done_d = 1'b1;
          fill_d       = '0;
          flush_sent_d = 1'b0;
        end
      end
      default: state_d = RX_CODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_CODE;
      active       <= 1'b0;
      fill_code    <= '0;
      permit_armed <= 1'b0;
      flush_sent   <= 1'b0;
      status_pulse <= 1'b0;
      error        <= 1'b0;
      flush        <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      active       <= link_enable;
      fill_code    <= fill_d;
      permit_armed <= armed_d;
      flush_sent   <= flush_sent_d;
      status_pulse <= status_d;
      error        <= error_d;
      flush        <= flush_d;
      frame_done   <= frame_done_d;
    end
  end

endmodule

// File: doc/scanner_link_receiver.md
Name: scanner_link_receiver

Overview:
Gondola-side receiver for the scanner serial link. It deserializes MSB-first status codes and data frames from the scanner and drives the link control lines back to it: active, transfer_permit and flush. Data payload bytes go to the downstream storage/downlink logic over a valid/ready byte interface.

Parameters:
DATA_BITS, 1024, payload bits following a data-header code (multiple of 8)
CODE_BITS, 8, width of a status/header code
TIMEOUT, 4096, clk cycles without an accepted bit mid-code/mid-frame before abort

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
transfer_data  input  1  serial bit from scanner, MSB first
transfer_clock  input  1  bit-valid strobe from scanner, sampled synchronously on clk
transfer_ready  output  1  receiver can accept a bit this cycle
active  output  1  link enable to scanner (= link_enable input, registered)
transfer_permit  output  1  permission for scanner to send its data frame
flush  output  1  one-cycle request for scanner to discard its buffer
link_enable  input  1  host enables scanner link
host_request  input  1  host wants the next scan's data
host_flush  input  1  host wants the buffer discarded
out_byte  output  8  payload byte
out_valid  output  1  out_byte valid
out_ready  input  1  consumer accepts out_byte
fill_code  output  3  last status code received (0 none, 1=50%, 2=80%, 3=90%, 4=100%)
status_pulse  output  1  one cycle when a status code 1-4 completes
frame_done  output  1  one cycle after the last payload byte is accepted by the consumer
error  output  1  one cycle on bad code or timeout
state  output  2  0 RX_CODE, 1 RX_DATA, 2 DRAIN

Behaviour:
- Reset (sync): all outputs 0. State RX_CODE, bit counter 0, shift register 0, fill_code 0, permit_armed 0.
- Bit accept: the receiver takes a bit on a rising clk when transfer_clock=1 and transfer_ready=1. It shifts left: shreg <= {shreg[6:0], transfer_data}.
- transfer_ready = !(out_valid && !out_ready). It drops in the same cycle a byte stalls, so the shift register never overflows.
- RX_CODE: after CODE_BITS accepted bits, decode the value in the same edge as the 8th bit. The counter clears.
  - Code 1..4: fill_code <= code, status_pulse for 1 cycle. Stay in RX_CODE.
  - Code 7: go to RX_DATA, clear transfer_permit and permit_armed.
  - Any other value: error pulse, fill_code unchanged, stay in RX_CODE.
- RX_DATA: every 8 accepted bits, load out_byte and raise out_valid in the next cycle.
  - out_valid holds until out_ready is seen.
  - After DATA_BITS bits, go to DRAIN.
- DRAIN: when the final byte handshake completes, pulse frame_done, set fill_code <= 0 and return to RX_CODE.
- Permit:
  - permit_armed sets on host_request, and holds until the code-7 header or rst.
  - transfer_permit = permit_armed && fill_code >= 2 && state==RX_CODE.
  - An early host_request is therefore held until the 80% code arrives.
- flush: one-cycle pulse when host_flush=1, fill_code==4, permit_armed=0 and state==RX_CODE. It is then not re-issued until a new fill_code update.
- If host_flush and host_request are asserted in the same cycle, request wins and no flush is issued.
- active is registered from link_enable with 1-cycle latency.
- When active=0: bits are ignored and the partial code is discarded. Bit counter and timeout clear, but fill_code is retained.
- Timeout:
  - The counter runs only when the bit count is nonzero (mid-code), or in RX_DATA with transfer_ready=1.
  - It resets on every accepted bit.
  - On reaching TIMEOUT: error pulse, discard the partial code/frame, drop any pending out_valid, return to RX_CODE.
- Counter widths: $clog2(DATA_BITS+1) for payload bits, $clog2(TIMEOUT+1) for the timeout counter. Neither wraps; both are compared with ==.
- A sync rst mid-frame returns to reset values on the next edge, with no frame_done and no error.

Decomposition:
- Shared package scanner_link_pkg holds:
  - Code constants: CODE_50=1, CODE_80=2, CODE_90=3, CODE_100=4, CODE_DATA=7.
  - The state encoding.
  - The DATA_BITS default. The scanner side reuses the same constants.
- One sub-module: link_deserializer. It holds the shift register, bit counter, byte strobe and transfer_ready/backpressure logic. The top level holds the FSM, permit/flush and timeout.

Test Plan:
- Send codes 1,2,3,4 with out_ready=1 -> status_pulse 4 times, fill_code 1,2,3,4. No error.
- Assert host_request after code 1 -> transfer_permit stays 0 until code 2 completes, then is 1. Header 7 -> permit 0 the next cycle.
- Header 7 + 1024 bits of pattern 0xA5,0x3C,... -> 128 bytes out in order, frame_done once, fill_code 0, state back to 0.
- Same frame with out_ready=0 for 20 cycles at byte 10 -> transfer_ready low throughout the stall. No byte lost or duplicated.
- Send code 0x05 -> one error pulse, fill_code unchanged. Stop bits after 300 payload bits -> error after TIMEOUT cycles, state 0.
- fill_code=4, assert host_flush -> single flush pulse. Then host_flush+host_request in the same cycle -> no flush, permit=1. rst mid-frame -> all outputs 0.
